ascii_bcd_stream_packer: RTL

//   Sequencing controller for the ASCII->packed-BCD datapath. Accepts ASCII

---
 rtl/ascii_bcd_stream_packer.sv | 110 +++++++++++
 1 files changed

// File: rtl/ascii_bcd_stream_packer.sv
// Purpose : packs ASCII decimal digits of one number into a right-justified BCD word with an error code.
// Latency : out_valid rises one cycle after the input transfer carrying in_last.
// Backpr. : in_ready drops while a word waits in OUTPUT; the word holds until out_ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_char   ASCII character stream, in_last marks the final character
//   out_valid/out_ready         packed word handshake
//   out_bcd                     packed BCD (zero when an error was flagged)
//   out_ndig                    digits accepted into the word
//   out_err                     00 ok, 01 non-digit, 10 overflow
module ascii_bcd_stream_packer #(
  parameter int DIGITS = 4,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_char,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [CW-1:0]         out_ndig,
  output logic [1:0]            out_err
);

  typedef enum logic [1:0] {COLLECT, DRAIN, OUTPUT} state_t;

  localparam logic [CW-1:0] DMAX = CW'(DIGITS);

  state_t              state, state_nxt;
  logic                live;      // low during reset and until the first clock after release
  logic [4*DIGITS-1:0] acc, acc_shift;
  logic [CW-1:0]       cnt;
  logic [1:0]          err;
  logic                in_fire, out_fire, is_digit, full, err_hit;

  assign in_ready  = live && (state != OUTPUT);
  assign out_valid = (state == OUTPUT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign full      = (cnt == DMAX);
  // Any character that would set the error code while collecting.
  assign err_hit   = !is_digit || full;

  generate
    if (DIGITS == 1) begin : g_shift1
      assign acc_shift = in_char[3:0];
    end else begin : g_shiftn
      assign acc_shift = {acc[4*DIGITS-5:0], in_char[3:0]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (in_fire) begin
          if (in_last)      state_nxt = OUTPUT;
          else if (err_hit) state_nxt = DRAIN;
        end
      end
      DRAIN:   if (in_fire && in_last) state_nxt = OUTPUT;
      OUTPUT:  if (out_fire) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Accumulator, digit count and error code. Only COLLECT updates them, so
  // the first error naturally wins: DRAIN and OUTPUT leave them frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      err <= 2'b00;
    end else if (out_fire) begin
      acc <= '0;
      cnt <= '0;
      err <= 2'b00;
    end else if (state == COLLECT && in_fire) begin
      if (is_digit && !full) begin
        acc <= acc_shift;
        cnt <= cnt + CW'(1);
      end else if (is_digit) begin
        err <= 2'b10;
      end else begin
        err <= 2'b01;
      end
    end
  end

  // Output fields read as zero except while a word is presented.
  assign out_bcd  = (out_valid && err == 2'b00) ? acc : '0;
  assign out_ndig = out_valid ? cnt : '0;
  assign out_err  = out_valid ? err : 2'b00;

endmodule
